// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one word per frame (start, LSB-first data,
// optional parity, 1 or 2 stop bits), paced by an upstream baud_en strobe.
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_STOP2
  } state_t;

  state_t               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 par_d;

  // Parity is fixed at accept time so the host may change tx_data mid-frame.
  assign par_d = (PARITY == 1) ? ~^tx_data : ^tx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_valid) begin
            shift_q <= tx_data;
            par_q   <= par_d;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        // WAIT aligns the start bit to a full baud period.
        S_WAIT: begin
          if (baud_en) begin
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_en) begin
            tx_q    <= shift_q[0];
            cnt_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_en) begin
            shift_q <= shift_q >> 1;
            if (cnt_q < CNT_LAST) begin
              tx_q  <= shift_q[1];
              cnt_q <= cnt_q + CNT_W'(1);
            end else if (PARITY != 0) begin
              tx_q    <= par_q;
              state_q <= S_PAR;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end
          end
        end
        S_PAR: begin
          if (baud_en) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (baud_en) begin
            tx_q <= 1'b1;
            if (STOP_BITS == 2) begin
              state_q <= S_STOP2;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_STOP2: begin
          if (baud_en) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = (state_q == S_IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations share clock, reset and a
// 1-in-4 baud strobe; expected line bits are queued at send and popped per baud.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_en;
  logic [7:0] data0, data1, data2;
  logic [4:0] data3;
  logic [3:0] valid_r;
  logic [3:0] tx_w, busy_w, done_w, ready_w;

  int vectors     = 0;
  int miscompares = 0;
  int bcnt        = 0;
  logic was_baud  = 1'b0;
  logic exp_q[$];

  int DB[4] = '{8, 8, 8, 5};
  int PB[4] = '{0, 2, 1, 0};
  int SB[4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_def (
    .clk(clk), .reset(reset), .baud_en(baud_en), .tx_data(data0), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .baud_en(baud_en), .tx_data(data1), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .baud_en(baud_en), .tx_data(data2), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_frame #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_s2d5 (
    .clk(clk), .reset(reset), .baud_en(baud_en), .tx_data(data3), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock step; inputs change at the falling edge, was_baud tells whether
  // the rising edge just passed carried a baud strobe.
  task automatic tick();
    @(negedge clk);
    was_baud = baud_en;
    bcnt     = (bcnt + 1) % 4;
    baud_en  = (bcnt == 0);
  endtask

  task automatic wait_baud(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!was_baud && n < 8);
    if (!was_baud) chk({tag, "_baud_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic push_frame(input int s, input logic [7:0] d);
    logic p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DB[s]; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (PB[s] == 2) exp_q.push_back(p);
    if (PB[s] == 1) exp_q.push_back(~p);
    for (int i = 0; i < SB[s]; i++) exp_q.push_back(1'b1);
  endtask

  task automatic start_frame(input int s, input logic [7:0] d, input logic hold);
    case (s)
      0: data0 = d;
      1: data1 = d;
      2: data2 = d;
      default: data3 = d[4:0];
    endcase
    valid_r[s] = 1'b1;
    push_frame(s, d);
    chk($sformatf("dut%0d_ready_before_accept", s), ready_w[s], 1'b1);
    tick();
    if (!hold) valid_r[s] = 1'b0;
  endtask

  // Captures one frame on dut s, comparing each baud period against the queue,
  // then checks the tx_done pulse and its one-cycle width.
  task automatic check_frame(input int s, input string tag, output int lat);
    logic found = 1'b0;
    int   idx   = 1;
    lat = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      lat++;
      if (tx_w[s] === 1'b0) found = 1'b1;
      else if (done_w[s] !== 1'b0) chk({tag, "_done_before_start"}, done_w[s], 1'b0);
    end
    chk({tag, "_start_seen"}, found, 1'b1);
    if (!found) begin
      exp_q.delete();
      return;
    end
    chk({tag, "_start_on_baud"}, was_baud, 1'b1);
    chk({tag, "_bit0_start"}, tx_w[s], exp_q.pop_front());
    while (exp_q.size() > 0) begin
      wait_baud(tag);
      chk($sformatf("%s_bit%0d", tag, idx), tx_w[s], exp_q.pop_front());
      chk($sformatf("%s_busy%0d", tag, idx), busy_w[s], 1'b1);
      chk($sformatf("%s_nodone%0d", tag, idx), done_w[s], 1'b0);
      chk($sformatf("%s_notready%0d", tag, idx), ready_w[s], 1'b0);
      idx++;
    end
    wait_baud(tag);
    chk({tag, "_done_pulse"}, done_w[s], 1'b1);
    chk({tag, "_busy_end"}, busy_w[s], 1'b0);
    chk({tag, "_ready_end"}, ready_w[s], 1'b1);
    chk({tag, "_tx_idle_end"}, tx_w[s], 1'b1);
    tick();
    chk({tag, "_done_one_clk"}, done_w[s], 1'b0);
    chk({tag, "_tx_after_done"}, tx_w[s], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic saw_done;
    reset   = 1'b1;
    baud_en = 1'b0;
    valid_r = '0;
    data0   = '0;
    data1   = '0;
    data2   = '0;
    data3   = '0;
    repeat (3) tick();
    chk("reset_tx", tx_w[0], 1'b1);
    chk("reset_busy", busy_w[0], 1'b0);
    chk("reset_done", done_w[0], 1'b0);
    chk("reset_ready", ready_w[0], 1'b1);
    chk("reset_tx_s2d5", tx_w[3], 1'b1);
    reset = 1'b0;
    repeat (5) tick();

    // 1: default frame
    start_frame(0, 8'hA5, 1'b0);
    check_frame(0, "t1", lat);
    chk("t1_latency_range", (lat >= 1 && lat <= 8), 1'b1);
    $display("t1 frame 0xA5 default, start latency %0d clks", lat);

    // 2: even then odd parity
    start_frame(1, 8'hA5, 1'b0);
    check_frame(1, "t2_even", lat);
    $display("t2 frame 0xA5 even parity");
    start_frame(2, 8'hA5, 1'b0);
    check_frame(2, "t2_odd", lat);
    $display("t2 frame 0xA5 odd parity");

    // 3: 5 data bits, 2 stop bits
    start_frame(3, 8'h13, 1'b0);
    check_frame(3, "t3", lat);
    $display("t3 frame 0x13 5N2");

    // 4: valid held high across two words
    start_frame(0, 8'h55, 1'b1);
    data0 = 8'h0F;
    check_frame(0, "t4a", lat);
    push_frame(0, 8'h0F);
    valid_r[0] = 1'b0;
    chk("t4_second_accepted_ready", ready_w[0], 1'b0);
    chk("t4_second_accepted_busy", busy_w[0], 1'b1);
    check_frame(0, "t4b", lat);
    $display("t4 back-to-back frames 0x55, 0x0F");

    // 5: accept coincides with a baud strobe
    for (int i = 0; i < 4 && !baud_en; i++) tick();
    chk("t5_baud_aligned", baud_en, 1'b1);
    start_frame(0, 8'h3C, 1'b0);
    check_frame(0, "t5", lat);
    chk_int("t5_start_latency", lat, 4);
    $display("t5 frame 0x3C accepted on baud edge, latency %0d clks", lat);

    // 6: reset during data bit 3, then a clean frame
    start_frame(0, 8'hA5, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 16 && tx_w[0] !== 1'b0; i++) tick();
    chk("t6_start_seen", tx_w[0], 1'b0);
    repeat (4) wait_baud("t6");
    tick();
    reset = 1'b1;
    #1;
    chk("t6_reset_tx", tx_w[0], 1'b1);
    chk("t6_reset_busy", busy_w[0], 1'b0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    repeat (60) begin
      tick();
      if (done_w[0] !== 1'b0) saw_done = 1'b1;
    end
    chk("t6_no_done_after_abort", saw_done, 1'b0);
    chk("t6_idle_tx", tx_w[0], 1'b1);
    start_frame(0, 8'hFF, 1'b0);
    check_frame(0, "t6_ff", lat);
    $display("t6 reset mid-frame then frame 0xFF");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
